// File: rtl/tt_um_suhas1403_serial_adder.sv
// Bit-serial add/subtract unit: WIDTH-bit operands are rippled one bit per clock
// through a registered carry; control and status travel on the bidirectional pins.
module tt_um_suhas1403_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sh_a_r;
    logic [WIDTH-1:0] sh_b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_next_s;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [7:0]       uo_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             ovf_r;

    logic             load_a_s;
    logic             load_b_s;
    logic             start_s;
    logic             sub_s;
    logic             do_load_a_s;
    logic             do_load_b_s;
    logic             do_start_s;
    logic             do_shift_s;
    logic             do_finish_s;
    logic             sum_s;
    logic             carry_next_s;
    logic             unused_s;

    assign load_a_s = uio_in[0];
    assign load_b_s = uio_in[1];
    assign start_s  = uio_in[2];
    assign sub_s    = uio_in[3];
    assign unused_s = ^{uio_in[7:4], ui_in};

    // One full-adder slice on the current LSBs of the operand shift registers.
    always_comb begin
        sum_s        = sh_a_r[0] ^ sh_b_r[0] ^ carry_r;
        carry_next_s = maj3(sh_a_r[0], sh_b_r[0], carry_r);
        res_next_s   = {sum_s, res_r[WIDTH-1:1]};
    end

    // Next-state and per-cycle action decode; start wins over loads outside RUN.
    always_comb begin
        state_next_s = state_r;
        do_load_a_s  = 1'b0;
        do_load_b_s  = 1'b0;
        do_start_s   = 1'b0;
        do_shift_s   = 1'b0;
        do_finish_s  = 1'b0;
        if (ena) begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_s) begin
                        do_start_s   = 1'b1;
                        state_next_s = RUN;
                    end else begin
                        do_load_a_s  = load_a_s;
                        do_load_b_s  = load_b_s;
                    end
                end
                RUN: begin
                    do_shift_s = 1'b1;
                    if (cnt_r == LAST_BIT) begin
                        do_finish_s  = 1'b1;
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand storage; only written while not running and no start is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
        end else begin
            if (do_load_a_s) begin
                a_r <= ui_in[WIDTH-1:0];
            end
            if (do_load_b_s) begin
                b_r <= ui_in[WIDTH-1:0];
            end
        end
    end

    // Serial datapath: subtraction is A + ~B with the carry seeded to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a_r  <= '0;
            sh_b_r  <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else if (do_start_s) begin
            sh_a_r  <= a_r;
            sh_b_r  <= sub_s ? ~b_r : b_r;
            carry_r <= sub_s;
            cnt_r   <= '0;
        end else if (do_shift_s) begin
            sh_a_r  <= sh_a_r >> 1;
            sh_b_r  <= sh_b_r >> 1;
            res_r   <= res_next_s;
            carry_r <= carry_next_s;
            cnt_r   <= cnt_r + CW'(1);
        end
    end

    // Visible status/result; the result and flags move only on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_r   <= 8'h00;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (do_start_s) begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (do_finish_s) begin
            // carry_r here is the carry into the MSB, so the XOR is signed overflow.
            uo_r   <= 8'(res_next_s);
            cout_r <= carry_next_s;
            ovf_r  <= carry_r ^ carry_next_s;
            busy_r <= 1'b0;
            done_r <= 1'b1;
        end
    end

    assign uo_out  = uo_r;
    assign uio_out = {ovf_r, done_r, busy_r, cout_r, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_suhas1403_serial_adder.sv
// Scoreboarded random/directed bench for the serial adder at WIDTH=8 and WIDTH=4;
// expected results come from plain integer arithmetic.
module tb_tt_um_suhas1403_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] ui_in8 = 8'h00, uio_in8 = 8'h00, uo_out8, uio_out8, uio_oe8;
    logic [7:0] ui_in4 = 8'h00, uio_in4 = 8'h00, uo_out4, uio_out4, uio_oe4;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] ma [2];
    logic [7:0] mb [2];
    int         mrun [2];
    logic [9:0] q8 [$];
    logic [9:0] q4 [$];
    logic       pd [2];
    logic       pb [2];
    logic [9:0] last [2];

    tt_um_suhas1403_serial_adder #(.WIDTH(8)) dut8 (
        .ui_in(ui_in8), .uo_out(uo_out8), .uio_in(uio_in8), .uio_out(uio_out8),
        .uio_oe(uio_oe8), .ena(ena), .clk(clk), .rst_n(rst_n)
    );

    tt_um_suhas1403_serial_adder #(.WIDTH(4)) dut4 (
        .ui_in(ui_in4), .uo_out(uo_out4), .uio_in(uio_in4), .uio_out(uio_out4),
        .uio_oe(uio_oe4), .ena(ena), .clk(clk), .rst_n(rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: {ovf, cout, result} from integer add/subtract of w-bit operands.
    function automatic logic [9:0] ref_op(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic sub);
        int mask, ua, ub, sa, sb, r, sr;
        logic c, v;
        mask = (1 << w) - 1;
        ua = int'(a) & mask;
        ub = int'(b) & mask;
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        r  = sub ? ua - ub : ua + ub;
        sr = sub ? sa - sb : sa + sb;
        c  = sub ? (ua >= ub) : (ua + ub > mask);
        v  = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
        return {v, c, 8'(r & mask)};
    endfunction

    // One clock of stimulus to DUT idx (other DUT idle); model tracks what it accepts.
    task automatic step(input int idx, input logic [7:0] d, input logic la, input logic lb,
                        input logic st, input logic sb, input logic e);
        if (idx == 0) begin
            ui_in8 = d; uio_in8 = {4'b0000, sb, st, lb, la};
            ui_in4 = 8'h00; uio_in4 = 8'h00;
        end else begin
            ui_in4 = d; uio_in4 = {4'b0000, sb, st, lb, la};
            ui_in8 = 8'h00; uio_in8 = 8'h00;
        end
        ena = e;
        @(posedge clk);
        if (e) begin
            if (mrun[idx] > 0) begin
                mrun[idx]--;
            end else if (st) begin
                if (idx == 0) begin
                    q8.push_back(ref_op(8, ma[0], mb[0], sb));
                    mrun[0] = 8;
                end else begin
                    q4.push_back(ref_op(4, ma[1], mb[1], sb));
                    mrun[1] = 4;
                end
            end else begin
                if (la) ma[idx] = d;
                if (lb) mb[idx] = d;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int idx, input int exp_busy, input int gap_at, input int gap_len);
        int bc = 0;
        bit got = 1'b0;
        logic bsy, dn;
        for (int cyc = 0; cyc < 60; cyc++) begin
            bsy = (idx == 0) ? uio_out8[5] : uio_out4[5];
            dn  = (idx == 0) ? uio_out8[6] : uio_out4[6];
            if (dn) begin
                got = 1'b1;
                break;
            end
            if (bsy) bc++;
            step(idx, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, !(cyc >= gap_at && cyc < gap_at + gap_len));
        end
        if (!got) begin
            n_chk++;
            $display("FAIL done_timeout: dut %0d no done within 60 cycles", idx);
        end else begin
            check(idx == 0 ? "busy_len8" : "busy_len4", bc, exp_busy);
        end
    endtask

    task automatic run(input int idx, input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input int gap_at, input int gap_len);
        step(idx, a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(idx, b, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(idx, 8'h00, 1'b0, 1'b0, 1'b1, sub, 1'b1);
        wait_done(idx, ((idx == 0) ? 8 : 4) + gap_len, gap_at, gap_len);
    endtask

    task automatic mon(input int idx, input logic dn, input logic bsy, input logic [9:0] outv,
                       input logic [3:0] low);
        logic [9:0] exp;
        if (!rst_n) begin
            pd[idx] = 1'b0;
            pb[idx] = 1'b0;
            return;
        end
        if (dn && !pd[idx]) begin
            if ((idx == 0 && q8.size() == 0) || (idx == 1 && q4.size() == 0)) begin
                n_chk++;
                $display("FAIL unexpected_done: dut %0d outputs %0h with empty queue", idx, outv);
            end else begin
                exp = (idx == 0) ? q8.pop_front() : q4.pop_front();
                check(idx == 0 ? "result8" : "result4", outv[7:0], exp[7:0]);
                check(idx == 0 ? "cout8" : "cout4", outv[8], exp[8]);
                check(idx == 0 ? "ovf8" : "ovf4", outv[9], exp[9]);
                check(idx == 0 ? "uio_low8" : "uio_low4", low, 4'h0);
            end
        end
        if (bsy && pb[idx]) check(idx == 0 ? "hold8" : "hold4", outv, last[idx]);
        last[idx] = outv;
        pd[idx] = dn;
        pb[idx] = bsy;
    endtask

    // Monitor: compares outputs against the scoreboard whenever done rises.
    always @(negedge clk) begin
        mon(0, uio_out8[6], uio_out8[5], {uio_out8[7], uio_out8[4], uo_out8}, uio_out8[3:0]);
        mon(1, uio_out4[6], uio_out4[5], {uio_out4[7], uio_out4[4], uo_out4}, uio_out4[3:0]);
    end

    task automatic clear_model();
        q8.delete();
        q4.delete();
        for (int i = 0; i < 2; i++) begin
            ma[i] = 8'h00; mb[i] = 8'h00; mrun[i] = 0;
        end
    endtask

    initial begin
        clear_model();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_uo8", uo_out8, 8'h00);
        check("rst_uio8", uio_out8, 8'h00);
        check("rst_oe8", uio_oe8, 8'hF0);
        check("rst_uio4", {uo_out4, uio_out4}, 16'h0000);
        check("rst_oe4", uio_oe4, 8'hF0);
        rst_n = 1'b1;

        run(0, 8'h5A, 8'h33, 1'b0, 0, 0);
        run(0, 8'hFF, 8'h01, 1'b0, 0, 0);
        run(0, 8'h7F, 8'h01, 1'b0, 0, 0);
        run(0, 8'h10, 8'h20, 1'b1, 0, 0);
        run(0, 8'h80, 8'h01, 1'b1, 0, 0);

        // Start with a simultaneous load: load must be ignored.
        step(0, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_done(0, 8, 0, 0);

        // Load while in DONE keeps done and the result.
        step(0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("done_hold", uio_out8[6], 1'b1);
        check("done_res_hold", uo_out8, 32'(ref_op(8, 8'h80, 8'h01, 1'b0) & 10'h0FF));
        step(0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Loads and start toggled during RUN have no effect.
        step(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) step(0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_done(0, 5, 0, 0);
        step(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_done(0, 8, 0, 0);

        // ena dropped for 3 cycles mid-RUN.
        run(0, 8'h9C, 8'h47, 1'b0, 3, 3);

        // Asynchronous reset 4 cycles into RUN, then a fresh operation.
        step(0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 8'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) step(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_uo8", uo_out8, 8'h00);
        check("abort_uio8", uio_out8, 8'h00);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 8'h3C, 8'h21, 1'b0, 0, 0);

        for (int i = 0; i < 20; i++)
            run(0, 8'($urandom), 8'($urandom), 1'($urandom), 0, 0);

        // WIDTH=4: one load writes both operands.
        step(1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_done(1, 4, 0, 0);
        for (int i = 0; i < 6; i++)
            run(1, 8'($urandom), 8'($urandom), 1'($urandom), 0, 0);

        repeat (2) @(negedge clk);
        check("q8_empty", q8.size(), 0);
        check("q4_empty", q4.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
